// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI target.
package spi_pkg;

   localparam int unsigned SPI_WORD_W = 8;
   localparam int unsigned CPOL_IDX   = 1;
   localparam int unsigned CPHA_IDX   = 0;

   localparam logic [SPI_WORD_W-1:0] UNDERRUN_BYTE = 8'h00;

   typedef enum logic {
      StIdle  = 1'b0,
      StShift = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer with asynchronous active-low reset and selectable reset value.
module spi_target_sync #(
   parameter logic ResetVal = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= ResetVal;
         r_sync <= ResetVal;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/spi_target.sv
// Oversampling SPI target, all four modes, MSB-first, one-entry TX holding register.
// Define SPI_TARGET_ERR_EN to add sticky underrun / frame-error flags with i_err_clr.
module spi_target
   import spi_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [1:0]            i_mode,
   input  logic                  i_sclk,
   input  logic                  i_cs_n,
   input  logic                  i_copi,
   output logic                  o_cipo,
   output logic                  o_cipo_oe,
   input  logic [SPI_WORD_W-1:0] i_tx,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic [SPI_WORD_W-1:0] o_rx,
   output logic                  o_rx_valid,
`ifdef SPI_TARGET_ERR_EN
   input  logic                  i_err_clr,
   output logic                  o_tx_underrun,
   output logic                  o_frame_err,
`endif
   output logic                  o_busy
);

   logic w_sclk_s, w_cs_s, w_copi_s;

   spi_target_sync #(.ResetVal(1'b0)) u_sync_sclk (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk), .o_q(w_sclk_s)
   );
   spi_target_sync #(.ResetVal(1'b1)) u_sync_cs (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_cs_n), .o_q(w_cs_s)
   );
   spi_target_sync #(.ResetVal(1'b0)) u_sync_copi (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_copi), .o_q(w_copi_s)
   );

   logic       r_sclk_q, r_cs_q;
   logic       r_sclk_rise, r_sclk_fall, r_cs_rise, r_cs_fall;
   logic [1:0] r_warm;
   logic       r_armed;

   // CS_n fall detection is armed only once the synchronizer has shown a real high after
   // reset, so a CS_n held low across reset cannot start a frame mid-transfer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_q    <= 1'b0;
         r_cs_q      <= 1'b1;
         r_sclk_rise <= 1'b0;
         r_sclk_fall <= 1'b0;
         r_cs_rise   <= 1'b0;
         r_cs_fall   <= 1'b0;
         r_warm      <= 2'b00;
         r_armed     <= 1'b0;
      end else begin
         r_sclk_q    <= w_sclk_s;
         r_cs_q      <= w_cs_s;
         r_sclk_rise <= w_sclk_s & ~r_sclk_q;
         r_sclk_fall <= ~w_sclk_s & r_sclk_q;
         r_cs_rise   <= w_cs_s & ~r_cs_q;
         r_cs_fall   <= ~w_cs_s & r_cs_q & r_armed;
         r_warm      <= {r_warm[0], 1'b1};
         r_armed     <= r_armed | (r_warm[1] & w_cs_s);
      end
   end

   spi_state_e            r_state;
   logic [1:0]            r_mode;
   logic [2:0]            r_cnt;
   logic [SPI_WORD_W-1:0] r_rx_sh, r_rx, r_tx_sh, r_hold;
   logic                  r_rx_valid, r_hold_full;

   logic                  w_lead, w_trail, w_in_frame, w_sample, w_shift, w_start;
   logic                  w_load, w_accept;
   logic [SPI_WORD_W-1:0] w_load_byte, w_rx_next;

   assign w_lead      = r_mode[CPOL_IDX] ? r_sclk_fall : r_sclk_rise;
   assign w_trail     = r_mode[CPOL_IDX] ? r_sclk_rise : r_sclk_fall;
   assign w_in_frame  = (r_state == StShift) & ~r_cs_rise;
   assign w_sample    = w_in_frame & (r_mode[CPHA_IDX] ? w_trail : w_lead);
   assign w_shift     = w_in_frame & (r_mode[CPHA_IDX] ? w_lead : w_trail);
   assign w_start     = (r_state == StIdle) & r_cs_fall;
   // Every byte boundary is a shift edge with the counter at zero, in both phases.
   assign w_load      = (w_start & ~i_mode[CPHA_IDX]) | (w_shift & (r_cnt == 3'd0));
   assign w_accept    = i_tx_valid & ~r_hold_full;
   assign w_load_byte = r_hold_full ? r_hold : UNDERRUN_BYTE;
   assign w_rx_next   = {r_rx_sh[SPI_WORD_W-2:0], w_copi_s};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else if (w_accept) begin
         r_hold      <= i_tx;
         r_hold_full <= 1'b1;
      end else if (w_load) begin
         r_hold_full <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_mode     <= 2'b00;
         r_cnt      <= 3'd0;
         r_rx_sh    <= '0;
         r_rx       <= '0;
         r_rx_valid <= 1'b0;
         r_tx_sh    <= '0;
      end else begin
         r_rx_valid <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (r_cs_fall) begin
                  r_state <= StShift;
                  r_mode  <= i_mode;
                  r_cnt   <= 3'd0;
                  r_rx_sh <= '0;
                  r_tx_sh <= w_load ? w_load_byte : '0;
               end
            end
            StShift: begin
               if (r_cs_rise) begin
                  r_state <= StIdle;
                  r_tx_sh <= '0;
               end else begin
                  if (w_sample) begin
                     r_rx_sh <= w_rx_next;
                     r_cnt   <= r_cnt + 3'd1;
                     if (r_cnt == 3'd7) begin
                        r_rx       <= w_rx_next;
                        r_rx_valid <= 1'b1;
                     end
                  end
                  if (w_shift) begin
                     r_tx_sh <= w_load ? w_load_byte : {r_tx_sh[SPI_WORD_W-2:0], 1'b0};
                  end
               end
            end
         endcase
      end
   end

   assign o_busy     = (r_state == StShift);
   assign o_cipo_oe  = o_busy;
   assign o_cipo     = o_busy & r_tx_sh[SPI_WORD_W-1];
   assign o_tx_ready = ~r_hold_full;
   assign o_rx       = r_rx;
   assign o_rx_valid = r_rx_valid;

`ifdef SPI_TARGET_ERR_EN
   logic r_tx_underrun, r_frame_err;
   logic w_underrun, w_frame_err;

   assign w_underrun  = w_load & ~r_hold_full;
   assign w_frame_err = (r_state == StShift) & r_cs_rise & (r_cnt != 3'd0);

   // A new error event in the clear cycle wins over the clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_underrun <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         if (w_underrun)     r_tx_underrun <= 1'b1;
         else if (i_err_clr) r_tx_underrun <= 1'b0;
         if (w_frame_err)    r_frame_err   <= 1'b1;
         else if (i_err_clr) r_frame_err   <= 1'b0;
      end
   end

   assign o_tx_underrun = r_tx_underrun;
   assign o_frame_err   = r_frame_err;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: bit-banged SPI controller plus a holding-register model.
`timescale 1ns/1ps
module tb_spi_target;

   localparam int H = 6;  // SCLK half period in i_clk cycles

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b1;
   logic [1:0] i_mode = 2'b00;
   logic       i_sclk = 1'b0;
   logic       i_cs_n = 1'b1;
   logic       i_copi = 1'b0;
   logic       o_cipo, o_cipo_oe;
   logic [7:0] i_tx = 8'h00;
   logic       i_tx_valid = 1'b0;
   logic       o_tx_ready;
   logic [7:0] o_rx;
   logic       o_rx_valid, o_busy;
`ifdef SPI_TARGET_ERR_EN
   logic       i_err_clr = 1'b0;
   logic       o_tx_underrun, o_frame_err;
`endif

   spi_target dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_sclk(i_sclk), .i_cs_n(i_cs_n),
      .i_copi(i_copi), .o_cipo(o_cipo), .o_cipo_oe(o_cipo_oe), .i_tx(i_tx),
      .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready), .o_rx(o_rx), .o_rx_valid(o_rx_valid),
`ifdef SPI_TARGET_ERR_EN
      .i_err_clr(i_err_clr), .o_tx_underrun(o_tx_underrun), .o_frame_err(o_frame_err),
`endif
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   int         n_cmp = 0, n_err = 0;
   int         tick_n = 0, feed_tick = -1;
   logic [7:0] feed_byte = 8'h00;
   logic [7:0] m_mosi [4];
   logic [7:0] m_miso [4];
   logic [7:0] m_exp [4];
   logic [7:0] rx_q [$];
   // Holding register and sticky-flag model
   logic       m_full = 1'b0, m_under = 1'b0, m_ferr = 1'b0;
   logic [7:0] m_hold = 8'h00;
   logic [7:0] junk;

   always @(negedge i_clk) if (i_rst_n && o_rx_valid) rx_q.push_back(o_rx);

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(negedge i_clk);
      tick_n++;
      i_tx_valid = (tick_n == feed_tick);
      if (tick_n == feed_tick) i_tx = feed_byte;
   endtask

   function automatic logic [7:0] model_load();
      logic [7:0] v;
      if (m_full) begin
         v = m_hold;
         m_full = 1'b0;
      end else begin
         v = 8'h00;
         m_under = 1'b1;
      end
      return v;
   endfunction

   task automatic preload(input logic [7:0] b);
      int waited = 0;
      while (!o_tx_ready && waited < 50) begin
         tick();
         waited++;
      end
      n_cmp++;
      if (o_tx_ready !== 1'b1) begin
         n_err++;
         $display("FAIL preload_ready: o_tx_ready=%b required 1 after %0d cycles", o_tx_ready,
                  waited);
      end
      i_tx = b;
      i_tx_valid = 1'b1;
      tick();
      m_full = 1'b1;
      m_hold = b;
   endtask

   // Runs one frame as the controller, then advances the model by the frame's load points.
   task automatic spi_frame(input logic [1:0] mode, input int nbits);
      int  nl;
      bit  fed;
      fed = (feed_tick >= 0);
      i_mode = mode;
      i_sclk = mode[1];
      rx_q.delete();
      repeat (H) tick();
      tick_n = 0;
      i_cs_n = 1'b0;
      if (!mode[0]) i_copi = m_mosi[0][7];
      repeat (H) tick();
      i_mode = 2'($urandom);
      for (int b = 0; b < nbits; b++) begin
         i_sclk = ~mode[1];
         if (mode[0]) i_copi = m_mosi[b/8][7-(b%8)];
         else m_miso[b/8][7-(b%8)] = o_cipo;
         repeat (H) tick();
         i_sclk = mode[1];
         if (mode[0]) m_miso[b/8][7-(b%8)] = o_cipo;
         else if (b + 1 < nbits) i_copi = m_mosi[(b+1)/8][7-((b+1)%8)];
         repeat (H) tick();
      end
      i_cs_n = 1'b1;
      repeat (2*H) tick();
      feed_tick = -1;
      nl = mode[0] ? (nbits + 7) / 8 : 1 + nbits / 8;
      for (int i = 0; i < nl; i++) begin
         junk = model_load();
         if (i < 4) m_exp[i] = junk;
         if (i == 0 && fed) begin
            m_full = 1'b1;
            m_hold = feed_byte;
         end
      end
      if (nbits % 8 != 0) m_ferr = 1'b1;
   endtask

   task automatic clear_flags();
`ifdef SPI_TARGET_ERR_EN
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      tick();
      n_cmp++;
      if (o_tx_underrun !== 1'b0 || o_frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL flag_clear: underrun=%b frame_err=%b required 0 0", o_tx_underrun,
                  o_frame_err);
      end
`endif
      m_under = 1'b0;
      m_ferr = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (o_rx !== 8'h00) begin n_err++; $display("FAIL rst_rx: %h required 00", o_rx); end
      n_cmp++; if (o_rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid: %b required 0", o_rx_valid); end
      n_cmp++; if (o_tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_tx_ready: %b required 1", o_tx_ready); end
      n_cmp++; if (o_cipo !== 1'b0) begin n_err++; $display("FAIL rst_cipo: %b required 0", o_cipo); end
      n_cmp++; if (o_cipo_oe !== 1'b0) begin n_err++; $display("FAIL rst_cipo_oe: %b required 0", o_cipo_oe); end
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: %b required 0", o_busy); end
`ifdef SPI_TARGET_ERR_EN
      n_cmp++;
      if (o_tx_underrun !== 1'b0 || o_frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL rst_flags: %b %b required 0 0", o_tx_underrun, o_frame_err);
      end
`endif
   endtask

   task automatic test_latency();
      logic [7:0] b;
      b = {1'b1, 7'($urandom)};
      preload(b);
      i_mode = 2'b00;
      i_sclk = 1'b0;
      repeat (H) tick();
      i_cs_n = 1'b0;
      repeat (3) tick();
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL lat_busy_early: %b required 0", o_busy); end
      tick();
      n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL lat_busy: %b required 1", o_busy); end
      n_cmp++; if (o_cipo_oe !== 1'b1) begin n_err++; $display("FAIL lat_oe: %b required 1", o_cipo_oe); end
      n_cmp++; if (o_cipo !== b[7]) begin n_err++; $display("FAIL lat_msb: %b required %b", o_cipo, b[7]); end
      i_cs_n = 1'b1;
      repeat (2*H) tick();
      junk = model_load();
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL lat_idle: %b required 0", o_busy); end
      n_cmp++; if (o_tx_ready !== ~m_full) begin n_err++; $display("FAIL lat_ready: %b required %b", o_tx_ready, ~m_full); end
   endtask

   task automatic test_modes();
      for (int m = 0; m < 4; m++) begin
         logic [7:0] tx, rx;
         tx = (m == 0) ? 8'hA5 : 8'h96;
         rx = (m == 0) ? 8'h3C : 8'h5A;
         m_mosi[0] = rx;
         preload(tx);
         spi_frame(2'(m), 8);
         n_cmp++;
         if (rx_q.size() != 1) begin
            n_err++;
            $display("FAIL mode%0d_rx_count: %0d strobes required 1", m, rx_q.size());
         end
         n_cmp++;
         if (rx_q.size() < 1 || rx_q[0] !== rx) begin
            n_err++;
            $display("FAIL mode%0d_rx: got %h required %h", m, o_rx, rx);
         end
         n_cmp++;
         if (m_miso[0] !== tx) begin
            n_err++;
            $display("FAIL mode%0d_cipo: got %h required %h", m, m_miso[0], tx);
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         logic [1:0] mode;
         int         nb;
         mode = 2'($urandom);
         nb = 1 + int'($urandom_range(2));
         for (int i = 0; i < 4; i++) m_mosi[i] = 8'($urandom);
         if (!m_full && $urandom_range(1) == 1) preload(8'($urandom));
         if ($urandom_range(1) == 1) begin
            feed_tick = 30;
            feed_byte = 8'($urandom);
         end
         spi_frame(mode, nb * 8);
         n_cmp++;
         if (rx_q.size() != nb) begin
            n_err++;
            $display("FAIL rand%0d_rx_count: %0d strobes required %0d", it, rx_q.size(), nb);
         end
         for (int i = 0; i < nb; i++) begin
            n_cmp++;
            if (m_miso[i] !== m_exp[i]) begin
               n_err++;
               $display("FAIL rand%0d_cipo[%0d] mode %0d: got %h required %h", it, i, mode,
                        m_miso[i], m_exp[i]);
            end
            n_cmp++;
            if (rx_q.size() <= i || rx_q[i] !== m_mosi[i]) begin
               n_err++;
               $display("FAIL rand%0d_rx[%0d] mode %0d: missing or wrong, required %h", it, i,
                        mode, m_mosi[i]);
            end
         end
         n_cmp++;
         if (o_tx_ready !== ~m_full) begin
            n_err++;
            $display("FAIL rand%0d_ready: %b required %b", it, o_tx_ready, ~m_full);
         end
      end
   endtask

   task automatic test_underrun();
      logic [7:0] want [3];
      want[0] = 8'hA5;
      want[1] = 8'h11;
      want[2] = 8'h00;
      clear_flags();
      for (int i = 0; i < 4; i++) m_mosi[i] = 8'($urandom);
      preload(8'hA5);
      feed_tick = 30;
      feed_byte = 8'h11;
      spi_frame(2'b00, 24);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (m_miso[i] !== want[i]) begin
            n_err++;
            $display("FAIL under_cipo[%0d]: got %h required %h", i, m_miso[i], want[i]);
         end
      end
`ifdef SPI_TARGET_ERR_EN
      n_cmp++;
      if (o_tx_underrun !== 1'b1) begin
         n_err++;
         $display("FAIL under_flag: %b required 1", o_tx_underrun);
      end
`endif
   endtask

   task automatic test_abort();
      logic [1:0] mode;
      clear_flags();
      m_mosi[0] = 8'($urandom);
      preload(8'($urandom));
      spi_frame(2'b00, 5);
      n_cmp++;
      if (rx_q.size() != 0) begin
         n_err++;
         $display("FAIL abort_no_strobe: %0d strobes required 0", rx_q.size());
      end
`ifdef SPI_TARGET_ERR_EN
      n_cmp++;
      if (o_frame_err !== 1'b1) begin
         n_err++;
         $display("FAIL abort_frame_err: %b required 1", o_frame_err);
      end
`endif
      mode = 2'($urandom);
      m_mosi[0] = 8'($urandom);
      if (!m_full) preload(8'($urandom));
      spi_frame(mode, 8);
      n_cmp++;
      if (rx_q.size() != 1 || rx_q[0] !== m_mosi[0]) begin
         n_err++;
         $display("FAIL abort_next_rx: %0d strobes, o_rx %h required one strobe of %h",
                  rx_q.size(), o_rx, m_mosi[0]);
      end
      n_cmp++;
      if (m_miso[0] !== m_exp[0]) begin
         n_err++;
         $display("FAIL abort_next_cipo: got %h required %h", m_miso[0], m_exp[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] fb;
      fb = 8'($urandom);
      for (int i = 0; i < 4; i++) m_mosi[i] = 8'($urandom);
      feed_tick = 3;
      feed_byte = fb;
      spi_frame(2'b00, 16);
      n_cmp++;
      if (m_miso[0] !== 8'h00) begin
         n_err++;
         $display("FAIL b2b_first: got %h required 00", m_miso[0]);
      end
      n_cmp++;
      if (m_miso[1] !== fb) begin
         n_err++;
         $display("FAIL b2b_second: got %h required %h", m_miso[1], fb);
      end
   endtask

   task automatic test_mid_reset();
      logic [1:0] mode;
      preload(8'($urandom));
      i_mode = 2'b00;
      i_sclk = 1'b0;
      repeat (H) tick();
      i_cs_n = 1'b0;
      repeat (8) tick();
      preload(8'($urandom));
      for (int b = 0; b < 3; b++) begin
         i_sclk = 1'b1;
         repeat (H) tick();
         i_sclk = 1'b0;
         repeat (H) tick();
      end
      i_sclk = 1'b1;
      repeat (2) tick();
      i_rst_n = 1'b0;
      #1;
      n_cmp++; if (o_rx !== 8'h00) begin n_err++; $display("FAIL mrst_rx: %h required 00", o_rx); end
      n_cmp++; if (o_tx_ready !== 1'b1) begin n_err++; $display("FAIL mrst_ready: %b required 1", o_tx_ready); end
      n_cmp++; if (o_cipo_oe !== 1'b0 || o_cipo !== 1'b0) begin n_err++; $display("FAIL mrst_cipo: oe %b cipo %b required 0 0", o_cipo_oe, o_cipo); end
      n_cmp++; if (o_busy !== 1'b0 || o_rx_valid !== 1'b0) begin n_err++; $display("FAIL mrst_busy: busy %b valid %b required 0 0", o_busy, o_rx_valid); end
`ifdef SPI_TARGET_ERR_EN
      n_cmp++; if (o_tx_underrun !== 1'b0 || o_frame_err !== 1'b0) begin n_err++; $display("FAIL mrst_flags: %b %b required 0 0", o_tx_underrun, o_frame_err); end
`endif
      m_full = 1'b0;
      m_under = 1'b0;
      m_ferr = 1'b0;
      repeat (2) tick();
      i_rst_n = 1'b1;
      i_cs_n = 1'b1;
      i_sclk = 1'b0;
      repeat (10) tick();
      mode = 2'($urandom);
      m_mosi[0] = 8'($urandom);
      preload(8'($urandom));
      spi_frame(mode, 8);
      n_cmp++;
      if (rx_q.size() != 1 || rx_q[0] !== m_mosi[0] || m_miso[0] !== m_exp[0]) begin
         n_err++;
         $display("FAIL mrst_recover: %0d strobes o_rx %h cipo %h required %h / %h",
                  rx_q.size(), o_rx, m_miso[0], m_mosi[0], m_exp[0]);
      end
   endtask

   initial begin
      #1 i_rst_n = 1'b0;
      repeat (3) tick();
      i_rst_n = 1'b1;
      repeat (5) tick();
      test_reset();
      test_latency();
      test_modes();
      test_random();
      test_underrun();
      test_abort();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
